uart_tx_param: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable frame format and a valid/ready handshake. It replaces the fixed 8N1, single-buffer transmitter in the TX_IR path: it accepts decoded IR bytes (or any word up to 9 bits) from upstream logic and serialises them LSB-first onto the UART line. It supports back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_param.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format enums, TX state encoding and baud default.
// Kept separate so the receive side can reuse the same encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int CLKS_PER_BIT_DEFAULT = 1250;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count and a registered not-full flag.
// The head word is presented combinationally on rdata_o.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ready_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             ready_q;
    logic             do_push, do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != (AW+1)'(DEPTH));
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised LSB first,
// optional parity, 1 or 2 stop bits, back-to-back frames with no idle gap.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_BITS-1:0]        i_data,
    output logic                        o_tx_serial,
    output logic                        o_busy,
    output logic                        o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 fin_q, done_q, busy_q;
    logic                 fin, pop, bit_end, not_empty, push_ok, fifo_nz_d;

    logic [DATA_BITS-1:0] fifo_rdata;
    logic [CNTW-1:0]      fifo_count;
    logic                 fifo_ready;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid),
        .pop_i   (pop),
        .wdata_i (i_data),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .ready_o (fifo_ready)
    );

    assign bit_end   = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign not_empty = (fifo_count != '0);
    assign push_ok   = i_valid && fifo_ready;
    assign fifo_nz_d = push_ok || (fifo_count > CNTW'(1)) || (fifo_count == CNTW'(1) && !pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        fin     = 1'b0;
        if (state_q == ST_IDLE) cnt_d = '0;
        else                    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    stop_d  = 1'b0;
                    if (bit_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        fin = 1'b1;
                        // Pop straight into the next start bit to keep frames gapless.
                        if (not_empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            shift_d = fifo_rdata;
            par_d   = 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q ^ (PARITY == int'(PAR_ODD));
            default:   tx_d = 1'b1;
        endcase
    end

    // The line is registered from the state, so tx_done trails the FSM by two stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            fin_q   <= fin;
            done_q  <= fin_q;
            busy_q  <= (state_d != ST_IDLE) || fifo_nz_d;
        end
    end

    assign o_tx_serial  = tx_q;
    assign o_tx_done    = done_q;
    assign o_busy       = busy_q;
    assign o_ready      = fifo_ready;
    assign o_fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: timeline model of FIFO/line/handshake plus a serial decoder.
// dut0 is 8N1; dut1/dut2 are 7E2/7O2 for the parity frames.
module tb_uart_tx_param;

    localparam int C      = 4;
    localparam int DEPTH  = 4;
    localparam int CNTW   = $clog2(DEPTH) + 1;
    localparam int FRAME0 = (1 + 8 + 0 + 1) * C;
    localparam int FRAME1 = (1 + 7 + 1 + 2) * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0] din = 8'h00;

    logic rdy0, tx0, busy0, done0, rdy1, tx1, busy1, done1, rdy2, tx2, busy2, done2;
    logic [CNTW-1:0] cnt0, cnt1, cnt2;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .o_ready(rdy0), .i_data(din),
        .o_tx_serial(tx0), .o_busy(busy0), .o_tx_done(done0), .o_fifo_count(cnt0));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(rdy1), .i_data(din[6:0]),
        .o_tx_serial(tx1), .o_busy(busy1), .o_tx_done(done1), .o_fifo_count(cnt1));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .i_valid(v2), .o_ready(rdy2), .i_data(din[6:0]),
        .o_tx_serial(tx2), .o_busy(busy2), .o_tx_done(done2), .o_fifo_count(cnt2));

    int n_chk = 0, n_pass = 0;
    int ecyc = 0, next_free = 0, cur_p = -1000000;
    logic [7:0] cur_w = 8'h00;
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    int dq[$];
    int accepted = 0, done_cnt = 0, rx_cnt = 0;
    bit mon_on = 1'b0;
    int mon_c = 0;
    logic [9:0] rx_bits = '0;

    task automatic chk(string tag, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, ecyc);
    endtask

    // Bit k of a frame: start, data LSB first, optional parity, then stop bits.
    function automatic logic frame_bit(logic [8:0] w, int k, int d, int p);
        logic [8:0] m;
        m = w & ((9'd1 << d) - 9'd1);
        if (k == 0) return 1'b0;
        if (k <= d) return w[k-1];
        if (k == d + 1 && p != 0) return (($countones(m) & 1) != 0) ^ (p == 2);
        return 1'b1;
    endfunction

    // One clock of dut0: advance the timeline model, then compare every output.
    task automatic tick();
        bit push, pop, e_done;
        logic e_tx;
        int idx;
        @(posedge clk);
        ecyc++;
        e_done = 1'b0;
        if (rst) begin
            mq.delete(); sent.delete(); dq.delete();
            next_free = 0; cur_p = -1000000; e_tx = 1'b1;
        end else begin
            idx  = ecyc - cur_p - 1;
            e_tx = (idx >= 0 && idx < FRAME0) ? frame_bit({1'b0, cur_w}, idx / C, 8, 0) : 1'b1;
            if (dq.size() > 0 && dq[0] == ecyc) begin
                e_done = 1'b1;
                void'(dq.pop_front());
            end
            pop  = (mq.size() > 0) && (ecyc >= next_free);
            push = v0 && (mq.size() < DEPTH);
            if (pop) begin
                cur_w = mq.pop_front();
                cur_p = ecyc;
                next_free = ecyc + FRAME0;
                dq.push_back(ecyc + FRAME0 + 1);
            end
            if (push) begin
                mq.push_back(din);
                sent.push_back(din);
                accepted++;
            end
        end
        #1;
        chk("tx", tx0, e_tx);
        chk("done", done0, e_done);
        chk("ready", rdy0, mq.size() < DEPTH);
        chk("count", cnt0, mq.size());
        chk("busy", busy0, (mq.size() > 0) || (ecyc < next_free));
        if (done0) done_cnt++;
        if (rst) mon_on = 1'b0;
        else if (!mon_on) begin
            if (tx0 == 1'b0) begin mon_on = 1'b1; mon_c = 0; end
        end else mon_c++;
        if (mon_on && (mon_c % C) == C / 2) begin
            rx_bits[mon_c / C] = tx0;
            if (mon_c / C == 9) begin
                mon_on = 1'b0;
                rx_cnt++;
                chk("rx_frame", {rx_bits[9], rx_bits[0]}, 2);
                if (sent.size() == 0) chk("rx_extra", 1, 0);
                else chk("rx_word", rx_bits[8:1], sent.pop_front());
            end
        end
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((busy0 || sent.size() != 0 || dq.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk(tag, 0, 1);
        repeat (3) tick();
    endtask

    task automatic push0(logic [7:0] w, string tag);
        int prev = accepted, n = 0;
        din = w;
        v0  = 1'b1;
        while (accepted == prev && n < 500) begin
            tick();
            n++;
        end
        v0 = 1'b0;
        if (accepted == prev) chk(tag, 0, 1);
    endtask

    initial begin
        int ta, t_fall, t_done, base_acc, base_done, base_rx, n, idx;
        bit saw_full;
        logic [0:9] a5_seq;

        repeat (3) tick();
        chk("rst_tx", tx0, 1);
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_count", cnt0, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 0xA5 on 8N1: latency, exact bit pattern, done timing
        a5_seq = 10'b0101001011;
        push0(8'hA5, "a5_push_timeout");
        ta = ecyc; t_fall = -1; t_done = -1;
        for (int i = 0; i < 100 && t_done < 0; i++) begin
            tick();
            if (t_fall < 0 && tx0 == 1'b0) t_fall = ecyc;
            if (t_fall >= 0 && ecyc - t_fall < FRAME0) chk("a5_bit", tx0, a5_seq[(ecyc - t_fall) / C]);
            if (done0) t_done = ecyc;
        end
        chk("a5_latency", t_fall - ta, 2);
        chk("a5_done_at", t_done - t_fall, 40);
        drain("a5_drain_timeout");

        // 0x13 on 7E2 and 7O2
        din = 8'h13; v1 = 1'b1; v2 = 1'b1;
        tick();
        v1 = 1'b0; v2 = 1'b0;
        ta = ecyc;
        for (int i = 0; i < FRAME1 + 4; i++) begin
            tick();
            idx = ecyc - ta - 2;
            if (idx >= 0 && idx < FRAME1) begin
                chk("even_line", tx1, frame_bit(9'h013, idx / C, 7, 1));
                chk("odd_line", tx2, frame_bit(9'h013, idx / C, 7, 2));
            end else begin
                chk("even_idle", tx1, 1);
                chk("odd_idle", tx2, 1);
            end
            if (idx == 8 * C + C / 2) begin
                chk("even_parity_bit", tx1, 1);
                chk("odd_parity_bit", tx2, 0);
            end
            chk("even_done", done1, idx == FRAME1);
            chk("odd_done", done2, idx == FRAME1);
        end
        chk("even_busy_end", busy1, 0);
        chk("odd_busy_end", busy2, 0);
        chk("even_cnt_end", cnt1 + cnt2, 0);
        chk("even_rdy_end", rdy1 && rdy2, 1);

        // burst of 6 words in consecutive cycles: fills the FIFO, frames gapless
        saw_full = 1'b0;
        base_done = done_cnt; base_rx = rx_cnt;
        for (int w = 0; w < 6; w++) begin
            push0(8'($urandom), "burst_push_timeout");
            if (!rdy0) saw_full = 1'b1;
        end
        drain("burst_drain_timeout");
        chk("burst_ready_dropped", saw_full, 1);
        chk("burst_done_count", done_cnt - base_done, 6);
        chk("burst_rx_count", rx_cnt - base_rx, 6);

        // reset mid-DATA with 2 words queued
        for (int w = 0; w < 3; w++) push0(8'($urandom), "rstq_push_timeout");
        chk("pre_rst_count", cnt0, 2);
        repeat (10) tick();
        base_done = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx", tx0, 1);
        chk("midrst_count", cnt0, 0);
        chk("midrst_busy", busy0, 0);
        repeat (60) tick();
        chk("midrst_no_done", done_cnt - base_done, 0);
        base_rx = rx_cnt;
        push0(8'h3C, "post_rst_push_timeout");
        drain("post_rst_drain_timeout");
        chk("post_rst_rx", rx_cnt - base_rx, 1);
        chk("post_rst_done", done_cnt - base_done, 1);

        // 200 random words with random valid
        base_acc = accepted; base_done = done_cnt; base_rx = rx_cnt; n = 0;
        while (accepted - base_acc < 200 && n < 40000) begin
            v0  = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            tick();
            n++;
        end
        v0 = 1'b0;
        if (n >= 40000) chk("rand_timeout", 0, 1);
        drain("rand_drain_timeout");
        chk("rand_done_count", done_cnt - base_done, 200);
        chk("rand_rx_count", rx_cnt - base_rx, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
